regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 46 ++++
 rtl/regfile_multiport.sv | 126 ++++++++++++
 tb/tb_regfile_multiport.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_multiport_pkg.sv
// Shared definitions for the multiport register file.
// Contents: controller state encoding, default sizing constants, and the
// register-count derivation used by the top and the scoreboard.
package regfile_multiport_pkg;

    // INIT walks every register to zero; READY is normal operation.
    typedef enum logic [0:0] {
        StInit  = 1'b0,
        StReady = 1'b1
    } rf_state_e;

    localparam int unsigned DefRegWidth  = 32;
    localparam int unsigned DefAddrWidth = 5;

    function automatic int unsigned reg_count(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one bit per register.
// Ports:
//   Clk_i, Rst_i     clock, synchronous active-high reset (clears all bits)
//   Set_i/Set_Sel_i  issue strobe and destination index (marks pending)
//   Clr_i/Clr_Sel_i  writeback strobe and index (clears pending)
//   Pending_o        current pending vector, bit i for register i
module regfile_scoreboard
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = DefAddrWidth,
    parameter bit          R0_IS_ZERO     = 1'b1,
    localparam int unsigned RegCount      = reg_count(REG_ADDR_WIDTH)
) (
    input  logic                      Clk_i,
    input  logic                      Rst_i,
    input  logic                      Set_i,
    input  logic [REG_ADDR_WIDTH-1:0] Set_Sel_i,
    input  logic                      Clr_i,
    input  logic [REG_ADDR_WIDTH-1:0] Clr_Sel_i,
    output logic [RegCount-1:0]       Pending_o
);

    logic [RegCount-1:0] pending_d, pending_q;

    always_comb begin
        pending_d = pending_q;
        if (Clr_i) begin
            pending_d[Clr_Sel_i] = 1'b0;
        end
        // Applied after the clear so a new producer supersedes the retiring one.
        if (Set_i && !(R0_IS_ZERO && (Set_Sel_i == '0))) begin
            pending_d[Set_Sel_i] = 1'b1;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign Pending_o = pending_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with post-reset clear sequence and busy scoreboard.
// Ports:
//   Clk_i, Rst_i   clock, synchronous active-high reset
//   Rd_Sel_i       packed read indices, port p at [p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   Rd_Data_o      packed read data, port p at [p*REG_WIDTH +: REG_WIDTH] (combinational)
//   Rd_Busy_o      pending flag of each port's selected register
//   Wr_We_i/Wr_Sel_i/Wr_Data_i  write port
//   Iss_Valid_i/Iss_Sel_i       issue strobe marking a destination pending
//   Ready_o        high once every register has been cleared after reset
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int unsigned REG_WIDTH      = DefRegWidth,
    parameter int unsigned REG_ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter bit          R0_IS_ZERO     = 1'b1,
    parameter bit          BYPASS         = 1'b1
) (
    input  logic                                   Clk_i,
    input  logic                                   Rst_i,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] Rd_Sel_i,
    output logic [NUM_RD_PORTS*REG_WIDTH-1:0]      Rd_Data_o,
    output logic [NUM_RD_PORTS-1:0]                Rd_Busy_o,
    input  logic                                   Wr_We_i,
    input  logic [REG_ADDR_WIDTH-1:0]              Wr_Sel_i,
    input  logic [REG_WIDTH-1:0]                   Wr_Data_i,
    input  logic                                   Iss_Valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]              Iss_Sel_i,
    output logic                                   Ready_o
);

    localparam int unsigned RegCount = reg_count(REG_ADDR_WIDTH);

    rf_state_e                 state_d, state_q;
    logic [REG_ADDR_WIDTH-1:0] cnt_d, cnt_q;
    logic [REG_WIDTH-1:0]      regs_q [RegCount];
    logic [RegCount-1:0]       pending;
    logic                      ready;
    logic                      wr_en;
    logic                      iss_en;

    assign ready  = (state_q == StReady);
    assign wr_en  = ready && Wr_We_i && !(R0_IS_ZERO && (Wr_Sel_i == '0));
    assign iss_en = ready && Iss_Valid_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == {REG_ADDR_WIDTH{1'b1}}) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: ;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage has no reset; contents are only trusted after the clear walk.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            if (!ready) begin
                regs_q[cnt_q] <= '0;
            end else if (wr_en) begin
                regs_q[Wr_Sel_i] <= Wr_Data_i;
            end
        end
    end

    regfile_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .R0_IS_ZERO     (R0_IS_ZERO)
    ) u_scoreboard (
        .Clk_i     (Clk_i),
        .Rst_i     (Rst_i),
        .Set_i     (iss_en),
        .Set_Sel_i (Iss_Sel_i),
        .Clr_i     (ready && Wr_We_i),
        .Clr_Sel_i (Wr_Sel_i),
        .Pending_o (pending)
    );

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [REG_ADDR_WIDTH-1:0] sel;
        logic                      is_r0;
        logic                      hit;
        logic [REG_WIDTH-1:0]      rd_data;
        logic                      rd_busy;

        assign sel   = Rd_Sel_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign is_r0 = R0_IS_ZERO && (sel == '0);
        assign hit   = BYPASS && Wr_We_i && (Wr_Sel_i == sel);

        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (ready && !is_r0) begin
                if (hit) begin
                    rd_data = Wr_Data_i;
                end else begin
                    rd_data = regs_q[sel];
                    rd_busy = pending[sel];
                end
            end
        end

        assign Rd_Data_o[p*REG_WIDTH +: REG_WIDTH] = rd_data;
        assign Rd_Busy_o[p]                        = rd_busy;
    end

    assign Ready_o = ready;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: a bypassing and a non-bypassing
// instance share stimulus; a behavioural model predicts every read each cycle.
module tb_regfile_multiport;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_sel;
    logic [63:0] rdata, rdata_nb;
    logic [1:0]  busy, busy_nb;
    logic        we, iss;
    logic [4:0]  wsel, isel;
    logic [31:0] wdata;
    logic        ready, ready_nb;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: cycles since reset release (saturating at 32), contents, pending.
    int          m_since = 0;
    logic [31:0] mregs [32];
    bit          mpend [32];

    regfile_multiport #(.BYPASS(1'b1)) dut (
        .Clk_i(clk), .Rst_i(rst), .Rd_Sel_i(rd_sel), .Rd_Data_o(rdata),
        .Rd_Busy_o(busy), .Wr_We_i(we), .Wr_Sel_i(wsel), .Wr_Data_i(wdata),
        .Iss_Valid_i(iss), .Iss_Sel_i(isel), .Ready_o(ready)
    );

    regfile_multiport #(.BYPASS(1'b0)) dut_nb (
        .Clk_i(clk), .Rst_i(rst), .Rd_Sel_i(rd_sel), .Rd_Data_o(rdata_nb),
        .Rd_Busy_o(busy_nb), .Wr_We_i(we), .Wr_Sel_i(wsel), .Wr_Data_i(wdata),
        .Iss_Valid_i(iss), .Iss_Sel_i(isel), .Ready_o(ready_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] sel, input bit byp, output bit b);
        b = 1'b0;
        if (m_since < 32 || sel == 5'd0) return 32'd0;
        if (byp && we && wsel == sel) return wdata;
        b = mpend[sel];
        return mregs[sel];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_since <= 0;
            for (int i = 0; i < 32; i++) mpend[i] <= 1'b0;
        end else if (m_since < 32) begin
            m_since <= m_since + 1;
            if (m_since == 31) for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
        end else begin
            if (we && wsel != 5'd0) mregs[wsel] <= wdata;
            if (we) mpend[wsel] <= 1'b0;
            if (iss && isel != 5'd0) mpend[isel] <= 1'b1;  // later NBA: set wins
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] d;
            logic [4:0]  s;
            bit          b;
            check("ready", {31'b0, ready}, (m_since == 32) ? 32'd1 : 32'd0);
            check("ready_nb", {31'b0, ready_nb}, (m_since == 32) ? 32'd1 : 32'd0);
            for (int p = 0; p < 2; p++) begin
                s = rd_sel[p*5 +: 5];
                d = mread(s, 1'b1, b);
                check($sformatf("rd_data%0d", p), rdata[p*32 +: 32], d);
                check($sformatf("rd_busy%0d", p), {31'b0, busy[p]}, {31'b0, b});
                d = mread(s, 1'b0, b);
                check($sformatf("nb_rd_data%0d", p), rdata_nb[p*32 +: 32], d);
                check($sformatf("nb_rd_busy%0d", p), {31'b0, busy_nb[p]}, {31'b0, b});
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; iss = 1'b0; wsel = '0; isel = '0; wdata = '0; rd_sel = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_rdata", rdata[31:0], 32'd0);

        // Release; write + issue in cycle 10 must be ignored.
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i == 10) begin
                we = 1'b1; wsel = 5'd3; wdata = 32'h55; iss = 1'b1; isel = 5'd4;
            end
            tick();
            we = 1'b0; iss = 1'b0;
            #3;
            check("init_ready", {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
        end
        rd_sel = {5'd3, 5'd4};
        #1;
        check("init_wr_ignored", rdata[63:32], 32'd0);
        check("init_iss_ignored", {30'b0, busy}, 32'd0);

        // Same-cycle write/read of x5.
        we = 1'b1; wsel = 5'd5; wdata = 32'h1111_1111;
        tick();
        wdata = 32'hDEAD_BEEF; rd_sel = {5'd5, 5'd0};
        #1;
        check("bypass_p1", rdata[63:32], 32'hDEAD_BEEF);
        check("nobypass_p1_old", rdata_nb[63:32], 32'h1111_1111);
        tick();
        we = 1'b0;
        #1;
        check("bypass_p1_next", rdata[63:32], 32'hDEAD_BEEF);
        check("nobypass_p1_next", rdata_nb[63:32], 32'hDEAD_BEEF);

        // x0 is hardwired.
        we = 1'b1; wsel = 5'd0; wdata = 32'h1234; rd_sel = {5'd0, 5'd0};
        #1;
        check("x0_bypass", rdata[31:0], 32'd0);
        tick();
        we = 1'b0;
        #1;
        check("x0_read", rdata[63:32], 32'd0);
        check("x0_busy", {30'b0, busy}, 32'd0);

        // Scoreboard on x7.
        iss = 1'b1; isel = 5'd7; rd_sel = {5'd7, 5'd7};
        tick();
        iss = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("x7_busy_hold", {30'b0, busy}, 32'd3);
            tick();
        end
        we = 1'b1; wsel = 5'd7; wdata = 32'h77; iss = 1'b1; isel = 5'd7;
        #1;
        check("x7_bypass_busy", {30'b0, busy}, 32'd0);
        check("x7_nb_busy", {30'b0, busy_nb}, 32'd3);
        tick();
        we = 1'b0; iss = 1'b0;
        #1;
        check("x7_set_wins", {30'b0, busy}, 32'd3);
        we = 1'b1; wdata = 32'h88;
        tick();
        we = 1'b0;
        #1;
        check("x7_cleared", {30'b0, busy}, 32'd0);
        check("x7_data", rdata[31:0], 32'h88);

        // Reset at clear index 20 restarts the walk.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check("midinit_ready", {31'b0, ready}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            #1;
            check("restart_ready", {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
        end
        rd_sel = {5'd5, 5'd7};
        #1;
        check("restart_cleared", rdata[63:32], 32'd0);

        // Randomised traffic, biased to a few registers so busy and bypass collide.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst   = ($urandom_range(0, 399) == 0);
            we    = 1'($urandom_range(0, 1));
            wsel  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 7));
            wdata = $urandom;
            iss   = 1'($urandom_range(0, 1));
            isel  = 5'($urandom_range(0, 7));
            for (int p = 0; p < 2; p++) begin
                rd_sel[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wsel
                                                               : 5'($urandom_range(0, 7));
            end
        end
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
